cook_sequencer: RTL
===================

// Module: cook_sequencer
// PURPOSE
// - Front-panel controller for the microwave cook timer: collects keypad digits as M:SS, loads them into the
//   3-digit BCD down-counter chain (minutes, seconds-tens, seconds-ones) and paces the chain's countdown with 1 Hz ticks.
// - Gates the magnetron on door state and start/stop keys, and sounds a done beep when the chain reaches zero.
// - Sits between the keypad/door inputs and the timer-digit chain.
// PARAMETERS
// - BEEP_TICKS  3   tick_1hz pulses DONE stays asserted before returning to IDLE (>=1)
// - QUICK_SEC   3   seconds-tens digit loaded by quick start (30 s); used only with QUICK_START_EN
// PORTS
// - clk           in   1   system clock; all state changes on posedge
// - clr           in   1   synchronous, active-high reset
// - tick_1hz      in   1   one-clk pulse per second
// - key_valid     in   1   one-clk strobe, key_digit valid
// - key_digit     in   4   BCD key value; values >9 ignored
// - start         in   1   one-clk start strobe
// - stop_clear    in   1   one-clk stop/clear strobe
// - door_closed   in   1   level, 1 = door shut
// - timer_zero    in   1   AND of the three digit zero flags from the chain
// - load_data     out  12  {min, sec_ten, sec_one} BCD to the chain's data inputs
// - timer_loadn   out  1   active-low load to the chain
// - timer_en      out  1   chain enable
// - mag_on        out  1   magnetron drive
// - beep          out  1   done indicator
// - state_o       out  3   current state code, for display/debug
// BEHAVIOUR
// - Reset (clr=1 at posedge): state IDLE, entry reg 0, load_data 0, timer_loadn 1, timer_en 0, mag_on 0, beep 0, beep count 0.
// - States (state_o): IDLE=0, ENTRY=1, LOAD=2, COOK=3, PAUSE=4, DONE=5.
// - Input priority per cycle: stop_clear > door open > start > key_valid; lower-priority strobes in the same cycle are dropped.
// - Key entry (IDLE/ENTRY only): on valid digit, {min,ten,one} <= {ten,one,key_digit}; IDLE->ENTRY. Keys are ignored in all other states.
// - ENTRY + start + door_closed + entry!=0 -> LOAD. If sec_ten>5, it saturates to 5 in load_data; other digits load as entered.
// - ENTRY + start with entry==0, or with the door open -> ignored, stay ENTRY.
// - LOAD (exactly 1 cycle): timer_loadn=0, timer_en=1; next state COOK. mag_on=0.
// - COOK: mag_on=1; timer_en=tick_1hz & ~timer_zero; timer_loadn=1.
//   - timer_zero=1 -> DONE, checked before tick, so the chain never wraps past 0:00.
//   - door_closed=0 -> PAUSE (mag_on drops on the next cycle).
//   - stop_clear -> PAUSE. start is ignored.
// - PAUSE: mag_on=0, timer_en=0, chain holds.
//   - start & door_closed -> COOK (no reload).
//   - stop_clear -> IDLE, entry cleared to 0.
// - DONE: beep=1, mag_on=0, timer_en=0.
//   - Count BEEP_TICKS ticks, then -> IDLE with entry cleared.
//   - stop_clear -> IDLE at once.
// - stop_clear in IDLE/ENTRY: clears entry, -> IDLE. clr mid-cook: forces reset values next edge, mag_on=0 at once.
// - All outputs are decoded from registered state plus tick_1hz/timer_zero only; no combinational path from the key or start inputs.
// CONFIGURATION
// - QUICK_START_EN defined:
//   - IDLE + start + door_closed loads {0,QUICK_SEC,0} via LOAD -> COOK (30 s cook).
//   - COOK + start also ignored.
// - QUICK_START_EN undefined: start in IDLE is ignored; QUICK_SEC unused.
// TESTING
// - clr; keys 1,3,0; start (door closed) -> load_data=12'h130, one LOAD cycle with loadn=0/en=1, then COOK, mag_on=1.
// - Cook 0:02 with ticks -> two timer_en pulses, timer_zero -> DONE, beep=1 for 3 ticks, then IDLE, mag_on=0.
// - COOK, door_closed=0 -> PAUSE, mag_on=0, no timer_en on ticks; door shut + start -> COOK, count resumes from held value.
// - Keys 0,7,5 -> load_data=12'h055 (ten saturated); start with entry 0 or door open -> stays ENTRY.
// - stop_clear in PAUSE -> IDLE, entry 0; start+stop_clear same cycle in ENTRY -> IDLE (stop wins).
// - QUICK_START_EN: start in IDLE -> load_data=12'h030, COOK; undefined: state stays IDLE.

Source files
------------

// File: rtl/cook_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cook_sequencer
// Description : Microwave front-panel sequencer. Collects M:SS keypad digits,
//               loads them into the external 3-digit BCD down-counter chain,
//               paces the countdown with 1 Hz ticks, gates the magnetron on
//               door/start/stop and beeps for BEEP_TICKS seconds when done.
//               Optional macro QUICK_START_EN: start in IDLE cooks 0:QUICK_SEC0.
// Revision    : 1.0 - initial release
// ============================================================================
module cook_sequencer #(
   parameter int BEEP_TICKS = 3,
   parameter int QUICK_SEC  = 3
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        tick_1hz,
   input  logic        key_valid,
   input  logic [3:0]  key_digit,
   input  logic        start,
   input  logic        stop_clear,
   input  logic        door_closed,
   input  logic        timer_zero,
   output logic [11:0] load_data,
   output logic        timer_loadn,
   output logic        timer_en,
   output logic        mag_on,
   output logic        beep,
   output logic [2:0]  state_o
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ENTRY = 3'd1;
   localparam logic [2:0] S_LOAD  = 3'd2;
   localparam logic [2:0] S_COOK  = 3'd3;
   localparam logic [2:0] S_PAUSE = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

`ifdef QUICK_START_EN
   localparam bit C_QUICK = 1'b1;
`else
   localparam bit C_QUICK = 1'b0;
`endif
   localparam logic [3:0] C_QUICK_TEN = 4'(QUICK_SEC);

   // Beep counter counts 0 .. BEEP_TICKS-1 ticks while in DONE
   localparam int            CW     = (BEEP_TICKS < 2) ? 1 : $clog2(BEEP_TICKS);
   localparam logic [CW-1:0] C_LAST = CW'(BEEP_TICKS - 1);

   logic [2:0]    r_state;
   logic [11:0]   r_entry;
   logic [11:0]   r_load;
   logic [CW-1:0] r_cnt;

   logic [2:0]    w_state_nx;
   logic [11:0]   w_entry_nx;
   logic [11:0]   w_load_nx;
   logic [CW-1:0] w_cnt_nx;
   logic [11:0]   w_shift;

   // Seconds-tens above 5 is not a valid time; clamp it on the way to the chain
   function automatic logic [11:0] f_sat(input logic [11:0] e);
      return {e[11:8], (e[7:4] > 4'd5) ? 4'd5 : e[7:4], e[3:0]};
   endfunction

   assign w_shift = {r_entry[7:0], key_digit};

   // Next-state decode; priority stop_clear > door open > start > key
   always_comb begin
      w_state_nx = r_state;
      w_entry_nx = r_entry;
      w_load_nx  = r_load;
      w_cnt_nx   = r_cnt;
      case (r_state)
         S_IDLE, S_ENTRY: begin
            if (stop_clear) begin
               w_state_nx = S_IDLE;
               w_entry_nx = 12'h000;
               w_load_nx  = 12'h000;
            end else if (!door_closed) begin
               w_state_nx = r_state;
            end else if (start) begin
               if (r_state == S_ENTRY && r_entry != 12'h000) begin
                  w_state_nx = S_LOAD;
                  w_load_nx  = f_sat(r_entry);
               end else if (r_state == S_IDLE && C_QUICK) begin
                  w_state_nx = S_LOAD;
                  w_load_nx  = {4'd0, C_QUICK_TEN, 4'd0};
               end
            end else if (key_valid && key_digit <= 4'd9) begin
               w_state_nx = S_ENTRY;
               w_entry_nx = w_shift;
               w_load_nx  = f_sat(w_shift);
            end
         end
         S_LOAD: w_state_nx = S_COOK;
         S_COOK: begin
            if (stop_clear || !door_closed) begin
               w_state_nx = S_PAUSE;
            end else if (timer_zero) begin
               w_state_nx = S_DONE;
               w_cnt_nx   = '0;
            end
         end
         S_PAUSE: begin
            if (stop_clear) begin
               w_state_nx = S_IDLE;
               w_entry_nx = 12'h000;
               w_load_nx  = 12'h000;
            end else if (start && door_closed) begin
               w_state_nx = S_COOK;
            end
         end
         S_DONE: begin
            if (stop_clear || (tick_1hz && r_cnt == C_LAST)) begin
               w_state_nx = S_IDLE;
               w_entry_nx = 12'h000;
               w_load_nx  = 12'h000;
               w_cnt_nx   = '0;
            end else if (tick_1hz) begin
               w_cnt_nx = r_cnt + 1'b1;
            end
         end
         default: begin
            w_state_nx = S_IDLE;
            w_entry_nx = 12'h000;
            w_load_nx  = 12'h000;
            w_cnt_nx   = '0;
         end
      endcase
   end

   // State, entry, load and beep-count registers
   always_ff @(posedge clk) begin
      if (clr) begin
         r_state <= S_IDLE;
         r_entry <= 12'h000;
         r_load  <= 12'h000;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nx;
         r_entry <= w_entry_nx;
         r_load  <= w_load_nx;
         r_cnt   <= w_cnt_nx;
      end
   end

   // Outputs depend only on registered state plus tick/zero (and clr for a fast magnetron cut)
   assign state_o     = r_state;
   assign load_data   = r_load;
   assign timer_loadn = (r_state != S_LOAD);
   assign timer_en    = (r_state == S_LOAD) ||
                        ((r_state == S_COOK) && tick_1hz && !timer_zero);
   assign mag_on      = (r_state == S_COOK) && !clr;
   assign beep        = (r_state == S_DONE);

endmodule
`default_nettype wire
